// File: rtl/bios_resp_tx_if.sv
// Response request bus from the BIOS command FSM plus the byte stream to the UART.
// No storage; pure signal bundle.
// Both halves use valid/ready: resp_* is the request handshake, tx_* the byte handshake.
interface bios_resp_tx_if;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_kind;
    logic [3:0]  resp_code;
    logic [1:0]  resp_size;
    logic [31:0] resp_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // The response formatter itself
    modport slave (
        input  resp_valid,
        output resp_ready,
        input  resp_kind,
        input  resp_code,
        input  resp_size,
        input  resp_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // The environment: request source and UART byte sink
    modport master (
        output resp_valid,
        input  resp_ready,
        output resp_kind,
        output resp_code,
        output resp_size,
        output resp_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/bios_resp_tx.sv
// Formats a BIOS response (ok / er<code> / pong / hex data) into newline-terminated ASCII bytes.
// First byte is presented the cycle after the request is accepted; one byte per accepted step.
// tx_ready low stalls the frame with tx_data/tx_valid held; resp_ready drops for the whole frame.
module bios_resp_tx #(
    parameter logic [7:0] NEWLINE = 8'h0A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    bios_resp_tx_if.slave     bus,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [1:0] KIND_OK   = 2'd0;
    localparam logic [1:0] KIND_ERR  = 2'd1;
    localparam logic [1:0] KIND_PONG = 2'd2;
    localparam logic [1:0] KIND_DATA = 2'd3;

    state_t      state;
    logic [3:0]  idx;
    logic [1:0]  kind_q;
    logic [3:0]  code_q;
    logic [1:0]  size_q;
    logic [31:0] data_q;

    // Lowercase ASCII hex digit for one nibble
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Index of the terminating newline, i.e. frame length minus one
    function automatic logic [3:0] last_idx(input logic [1:0] kind, input logic [1:0] size);
        logic [3:0] r;
        case (kind)
            KIND_OK:   r = 4'd2;
            KIND_ERR:  r = 4'd3;
            KIND_PONG: r = 4'd4;
            default:   r = (size == 2'd0) ? 4'd2 : (size == 2'd1) ? 4'd4 : 4'd8;
        endcase
        return r;
    endfunction

    // Byte at position idx of the frame described by the given fields
    function automatic logic [7:0] frame_byte(
        input logic [1:0]  kind,
        input logic [3:0]  code,
        input logic [1:0]  size,
        input logic [31:0] data,
        input logic [3:0]  pos_idx
    );
        logic [3:0] last;
        logic [2:0] digit;
        logic [7:0] b;
        last  = last_idx(kind, size);
        digit = 3'd0;
        b     = NEWLINE;
        if (pos_idx < last) begin
            case (kind)
                KIND_OK:  b = (pos_idx == 4'd0) ? 8'h6F : 8'h6B;
                KIND_ERR: b = (pos_idx == 4'd0) ? 8'h65 :
                              (pos_idx == 4'd1) ? 8'h72 : hex_char(code);
                KIND_PONG: begin
                    case (pos_idx)
                        4'd0:    b = 8'h70;
                        4'd1:    b = 8'h6F;
                        4'd2:    b = 8'h6E;
                        default: b = 8'h67;
                    endcase
                end
                default: begin
                    // First digit is the most significant nibble of the right-aligned payload
                    digit = 3'(last - 4'd1 - pos_idx);
                    b     = hex_char(4'(data >> {digit, 2'b00}));
                end
            endcase
        end
        return b;
    endfunction

    assign bus.resp_ready = (state == IDLE);
    assign busy           = (state == SEND);

    // Frame sequencer: latch request, present one byte at a time, registered tx outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= 4'd0;
            kind_q      <= 2'd0;
            code_q      <= 4'd0;
            size_q      <= 2'd0;
            data_q      <= 32'd0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= 8'h00;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (bus.resp_valid) begin
                        kind_q       <= bus.resp_kind;
                        code_q       <= bus.resp_code;
                        size_q       <= bus.resp_size;
                        data_q       <= bus.resp_data;
                        idx          <= 4'd0;
                        state        <= SEND;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= frame_byte(bus.resp_kind, bus.resp_code,
                                                   bus.resp_size, bus.resp_data, 4'd0);
                    end
                end
                SEND: begin
                    // tx_valid is always high here, so tx_ready alone marks the byte step
                    if (bus.tx_ready) begin
                        if (idx == last_idx(kind_q, size_q)) begin
                            state        <= IDLE;
                            idx          <= 4'd0;
                            bus.tx_valid <= 1'b0;
                            bus.tx_data  <= 8'h00;
                        end else begin
                            idx         <= idx + 4'd1;
                            bus.tx_data <= frame_byte(kind_q, code_q, size_q, data_q,
                                                      idx + 4'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bios_resp_tx.md
BIOS_RESP_TX -- requirements
Module: bios_resp_tx

Interface
REQ-001 SHALL have parameter NEWLINE, default 8'h0A, terminator byte appended to every response.
REQ-002 SHALL have port clk  input  1  single clock for all sequential logic.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clk_en  input  1  global step enable; no state changes when low.
REQ-005 SHALL have port resp_valid  input  1  response request from BIOS command FSM.
REQ-006 SHALL have port resp_ready  output  1  block can accept a request.
REQ-007 SHALL have port resp_kind  input  2  0=OK, 1=ERR, 2=PONG, 3=DATA.
REQ-008 SHALL have port resp_code  input  4  BIOS error code, used for ERR only.
REQ-009 SHALL have port resp_size  input  2  DATA width: 0=byte, 1=half, 2 or 3=word.
REQ-010 SHALL have port resp_data  input  32  DATA payload, right-aligned.
REQ-011 SHALL have port tx_data  output  8  ASCII byte to UART transmitter.
REQ-012 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-013 SHALL have port tx_ready  input  1  UART transmitter accepts byte.
REQ-014 SHALL have port busy  output  1  response frame in progress.

Function
REQ-015 SHALL implement states IDLE and SEND; busy = (state == SEND).
REQ-016 SHALL drive resp_ready = 1 in IDLE and 0 in SEND; resp_ready SHALL NOT depend on tx_ready.
REQ-017 SHALL accept a request when resp_valid & resp_ready & clk_en; it latches kind, code, size and data, clears byte index to 0 and enters SEND.
REQ-018 SHALL advance one byte when tx_valid & tx_ready & clk_en (byte step).
REQ-019 SHALL assert tx_valid in SEND only; tx_data and tx_valid SHALL hold stable until the byte step occurs.
REQ-020 SHALL drive tx_data = 8'h00 in IDLE.
REQ-021 SHALL emit OK as "ok" + NEWLINE (3 bytes).
REQ-022 SHALL emit ERR as "er", one lowercase hex digit of code, NEWLINE (4 bytes).
REQ-023 SHALL emit PONG as "pong" + NEWLINE (5 bytes).
REQ-024 SHALL emit DATA as lowercase hex digits, MSB nibble first, then NEWLINE: size 0 = 2 digits of data[7:0] (3 bytes), size 1 = 4 digits of data[15:0] (5 bytes), size 2/3 = 8 digits of data[31:0] (9 bytes).
REQ-025 SHALL encode nibbles 0-9 as 8'h30-8'h39 and a-f as 8'h61-8'h66.
REQ-026 SHALL, on the byte step of the last byte (index == length-1), return to IDLE; otherwise increment the index by 1.
REQ-027 SHALL leave a gap of at least one cycle with tx_valid low between consecutive frames.
REQ-028 SHALL ignore changes on resp_* inputs during SEND; only the latched values are used.
REQ-029 SHALL take no action with clk_en low, even if tx_ready or resp_valid is high: state, index and outputs hold.
REQ-030 SHALL use a byte index of 4 bits; the index SHALL never exceed 8.

Reset
REQ-031 SHALL, while rst is low, force state IDLE, index 0, latched fields 0, tx_valid 0, tx_data 8'h00, busy 0 and resp_ready 1, without waiting for a clock edge.
REQ-032 SHALL, on reset during SEND, abort the frame at once; no remaining bytes are sent after reset is released.
REQ-033 SHALL be able to accept a request on the first clk_en cycle after rst goes high.

Verification
REQ-034 OK, tx_ready=1, clk_en=1 -> bytes 6F 6B 0A on 3 consecutive cycles, then IDLE.
REQ-035 ERR with code=1 -> 65 72 31 0A; code=4'hB -> 65 72 62 0A.
REQ-036 DATA size=2, data=32'hDEADBEEF -> 64 65 61 64 62 65 65 66 0A; size=0, same data -> 65 66 0A.
REQ-037 PONG with tx_ready low for 5 cycles on the 2nd byte -> tx_data holds 6F with tx_valid high; the full frame 70 6F 6E 67 0A is sent, no byte dropped or repeated.
REQ-038 clk_en toggled 1/0 during DATA size=1, data=16'h1234 -> 31 32 33 34 0A, advancing only on clk_en-high cycles.
REQ-039 rst pulsed low after the 2nd byte of PONG -> tx_valid 0 immediately; after release resp_ready=1, and a following OK request emits only 6F 6B 0A.
